// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the servo PWM ramp controller.
package pwm_pkg;

    localparam int unsigned PWM_W              = 28;
    localparam int unsigned STEP_DEF           = 500;
    localparam int unsigned DUTY_MIN_DEF       = 50_000;
    localparam int unsigned DUTY_MAX_DEF       = 100_000;
    localparam int unsigned PERIOD_MIN_DEF     = 100_000;
    localparam int unsigned PERIOD_DEFAULT_DEF = 1_000_000;
    localparam int unsigned TIMEOUT_DEF        = 50;
    localparam int unsigned FAILSAFE_DUTY_DEF  = 75_000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_FAILSAFE = 2'd3
    } servo_state_e;

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Target handshake from the Nios PIO into the servo ramp controller.
interface servo_ramp_ctrl_if #(
    parameter int unsigned W = pwm_pkg::PWM_W
);
    logic [W-1:0] tgt_duty;
    logic [W-1:0] tgt_period;
    logic         tgt_valid;
    logic         tgt_ready;

    modport master (
        output tgt_duty,
        output tgt_period,
        output tgt_valid,
        input  tgt_ready
    );

    modport slave (
        input  tgt_duty,
        input  tgt_period,
        input  tgt_valid,
        output tgt_ready
    );
endinterface

// File: rtl/period_watchdog.sv
// Counts PWM periods since the last applied target, saturating at TIMEOUT.
module period_watchdog #(
    parameter int unsigned TIMEOUT = pwm_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Flags the tick that reaches the limit so the caller can act on that same edge.
    assign expired = (count == LIMIT) || (tick && !clear && count == LIMIT - 1'b1);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Servo PWM controller: latches clamped targets, ramps duty once per period, failsafe on stale targets.
module servo_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned W              = PWM_W,
    parameter int unsigned STEP           = STEP_DEF,
    parameter int unsigned DUTY_MIN       = DUTY_MIN_DEF,
    parameter int unsigned DUTY_MAX       = DUTY_MAX_DEF,
    parameter int unsigned PERIOD_MIN     = PERIOD_MIN_DEF,
    parameter int unsigned PERIOD_DEFAULT = PERIOD_DEFAULT_DEF,
    parameter int unsigned TIMEOUT        = TIMEOUT_DEF,
    parameter int unsigned FAILSAFE_DUTY  = FAILSAFE_DUTY_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    servo_ramp_ctrl_if.slave        tgt,
    input  logic                    arm,
    input  logic                    period_end,
    output logic [W-1:0]            duty,
    output logic [W-1:0]            period,
    output logic [1:0]              state,
    output logic                    failsafe
);
    localparam logic [W-1:0] STEP_V = W'(STEP);
    localparam logic [W-1:0] DMIN_V = W'(DUTY_MIN);
    localparam logic [W-1:0] DMAX_V = W'(DUTY_MAX);
    localparam logic [W-1:0] PMIN_V = W'(PERIOD_MIN);
    localparam logic [W-1:0] PDEF_V = W'(PERIOD_DEFAULT);
    localparam logic [W-1:0] FS_V   = W'(FAILSAFE_DUTY);

    servo_state_e state_q;

    logic         pend_full;
    logic [W-1:0] pend_duty;
    logic [W-1:0] pend_period;
    logic [W-1:0] goal;

    logic [W-1:0] acc_duty;
    logic [W-1:0] acc_period;
    logic [W-1:0] duty_hi;
    logic [W-1:0] eff_goal;
    logic [W-1:0] eff_period;
    logic [W-1:0] stepped;
    logic [W-1:0] ramp_duty;
    logic [W-1:0] fs_duty;
    logic [W-1:0] start_duty;

    logic accept;
    logic apply;
    logic wd_tick;
    logic wd_expired;

    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] dst);
        logic [W-1:0] gap;
        if (cur < dst) begin
            gap = dst - cur;
            return cur + ((gap > STEP_V) ? STEP_V : gap);
        end else begin
            gap = cur - dst;
            return cur - ((gap > STEP_V) ? STEP_V : gap);
        end
    endfunction

    assign tgt.tgt_ready = ~pend_full;
    assign accept        = tgt.tgt_valid && !pend_full;
    assign apply         = arm && period_end && pend_full;
    assign wd_tick       = arm && period_end && (state_q == ST_RAMP || state_q == ST_HOLD);
    assign state         = state_q;

    always_comb begin
        acc_period = (tgt.tgt_period < PMIN_V) ? PMIN_V : tgt.tgt_period;
        duty_hi    = (DMAX_V < acc_period) ? DMAX_V : acc_period;
        acc_duty   = (tgt.tgt_duty < DMIN_V) ? DMIN_V : tgt.tgt_duty;
        if (acc_duty > duty_hi) begin
            acc_duty = duty_hi;
        end
    end

    // Step toward the goal that will be in force after this edge, then pull under the new period.
    always_comb begin
        eff_goal   = apply ? pend_duty : goal;
        eff_period = apply ? pend_period : period;
        stepped    = step_toward(duty, eff_goal);
        ramp_duty  = (stepped > eff_period) ? eff_period : stepped;
        fs_duty    = (FS_V > period) ? period : FS_V;
        start_duty = (DMIN_V > pend_period) ? pend_period : DMIN_V;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_full   <= 1'b0;
            pend_duty   <= '0;
            pend_period <= '0;
        end else if (accept) begin
            pend_full   <= 1'b1;
            pend_duty   <= acc_duty;
            pend_period <= acc_period;
        end else if (apply) begin
            pend_full   <= 1'b0;
        end
    end

    period_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (wd_tick),
        .clear   (apply),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            duty     <= '0;
            period   <= PDEF_V;
            goal     <= '0;
            failsafe <= 1'b0;
        end else if (!arm) begin
            state_q  <= ST_IDLE;
            duty     <= '0;
            failsafe <= 1'b0;
        end else if (period_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_full) begin
                        period  <= pend_period;
                        goal    <= pend_duty;
                        duty    <= start_duty;
                        state_q <= ST_RAMP;
                    end
                end
                default: begin
                    if (apply) begin
                        period   <= pend_period;
                        goal     <= pend_duty;
                        duty     <= ramp_duty;
                        failsafe <= 1'b0;
                        state_q  <= (ramp_duty == pend_duty) ? ST_HOLD : ST_RAMP;
                    end else if (state_q != ST_FAILSAFE && wd_expired) begin
                        duty     <= fs_duty;
                        failsafe <= 1'b1;
                        state_q  <= ST_FAILSAFE;
                    end else if (state_q == ST_RAMP) begin
                        duty <= ramp_duty;
                        if (ramp_duty == goal) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl: ramp, clamping, handshake timing, failsafe, disarm and reset.
module tb_servo_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm;
    logic        period_end;
    logic [27:0] duty;
    logic [27:0] period;
    logic [1:0]  state;
    logic        failsafe;

    int compared   = 0;
    int mismatched = 0;

    servo_ramp_ctrl_if #(.W(28)) tgt_if ();

    servo_ramp_ctrl #(.W(28)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tgt        (tgt_if),
        .arm        (arm),
        .period_end (period_end),
        .duty       (duty),
        .period     (period),
        .state      (state),
        .failsafe   (failsafe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_pe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) period_end = 1'b1;
            @(negedge clk) period_end = 1'b0;
        end
    endtask

    task automatic offer(input logic [27:0] d, input logic [27:0] p);
        int n = 0;
        @(negedge clk);
        tgt_if.tgt_duty   = d;
        tgt_if.tgt_period = p;
        tgt_if.tgt_valid  = 1'b1;
        while (!tgt_if.tgt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", 32'(tgt_if.tgt_ready), 1);
        @(negedge clk);
        tgt_if.tgt_valid = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n           = 1'b0;
        arm               = 1'b0;
        period_end        = 1'b0;
        tgt_if.tgt_duty   = '0;
        tgt_if.tgt_period = '0;
        tgt_if.tgt_valid  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_duty",     32'(duty), 0);
        chk("rst_period",   32'(period), 1_000_000);
        chk("rst_state",    32'(state), 0);
        chk("rst_ready",    32'(tgt_if.tgt_ready), 1);
        chk("rst_failsafe", 32'(failsafe), 0);
        reset_n = 1'b1;

        // Basic ramp 50_000 -> 60_000
        arm = 1'b1;
        offer(28'd60_000, 28'd1_000_000);
        chk("acc_ready_low", 32'(tgt_if.tgt_ready), 0);
        chk("acc_duty_idle", 32'(duty), 0);
        chk("acc_state_idle", 32'(state), 0);
        pulse_pe(1);
        chk("start_duty",  32'(duty), 50_000);
        chk("start_state", 32'(state), 1);
        chk("start_ready", 32'(tgt_if.tgt_ready), 1);
        pulse_pe(19);
        chk("ramp19_duty",  32'(duty), 59_500);
        chk("ramp19_state", 32'(state), 1);
        pulse_pe(1);
        chk("ramp20_duty",  32'(duty), 60_000);
        chk("ramp20_state", 32'(state), 2);

        // Target offered on the same edge as period_end
        @(negedge clk);
        tgt_if.tgt_duty   = 28'd62_000;
        tgt_if.tgt_period = 28'd1_000_000;
        tgt_if.tgt_valid  = 1'b1;
        period_end        = 1'b1;
        @(negedge clk);
        tgt_if.tgt_valid  = 1'b0;
        period_end        = 1'b0;
        chk("coin_duty",  32'(duty), 60_000);
        chk("coin_ready", 32'(tgt_if.tgt_ready), 0);
        chk("coin_state", 32'(state), 2);
        repeat (3) @(negedge clk);
        chk("coin_ready_held", 32'(tgt_if.tgt_ready), 0);
        chk("coin_duty_held",  32'(duty), 60_000);
        pulse_pe(1);
        chk("coin_applied_duty",  32'(duty), 60_500);
        chk("coin_applied_state", 32'(state), 1);
        chk("coin_applied_ready", 32'(tgt_if.tgt_ready), 1);
        pulse_pe(3);
        chk("hold62_duty",  32'(duty), 62_000);
        chk("hold62_state", 32'(state), 2);

        // Watchdog: 50 period_ends after the last applied target
        pulse_pe(46);
        chk("wd49_failsafe", 32'(failsafe), 0);
        chk("wd49_state",    32'(state), 2);
        pulse_pe(1);
        chk("wd50_failsafe", 32'(failsafe), 1);
        chk("wd50_duty",     32'(duty), 75_000);
        chk("wd50_state",    32'(state), 3);
        chk("wd50_period",   32'(period), 1_000_000);
        pulse_pe(2);
        chk("fs_duty_stays", 32'(duty), 75_000);

        // Clamped target out of failsafe: duty 200_000 -> 100_000, period 10 -> 100_000
        offer(28'd200_000, 28'd10);
        pulse_pe(1);
        chk("clamp_period",   32'(period), 100_000);
        chk("clamp_duty",     32'(duty), 75_500);
        chk("clamp_state",    32'(state), 1);
        chk("clamp_failsafe", 32'(failsafe), 0);
        pulse_pe(48);
        chk("clamp_ramp_duty",  32'(duty), 99_500);
        chk("clamp_ramp_state", 32'(state), 1);
        pulse_pe(1);
        chk("clamp_top_duty",  32'(duty), 100_000);
        chk("clamp_top_state", 32'(state), 2);
        chk("invariant", 32'(duty <= period), 1);
        pulse_pe(1);
        chk("wd_again_state", 32'(state), 3);
        chk("wd_again_duty",  32'(duty), 75_000);

        // Disarm mid-ramp
        offer(28'd90_000, 28'd1_000_000);
        pulse_pe(2);
        chk("pre_disarm_duty",   32'(duty), 76_000);
        chk("pre_disarm_period", 32'(period), 1_000_000);
        @(negedge clk) arm = 1'b0;
        @(negedge clk);
        chk("disarm_duty",     32'(duty), 0);
        chk("disarm_state",    32'(state), 0);
        chk("disarm_failsafe", 32'(failsafe), 0);
        pulse_pe(1);
        chk("disarm_pe_duty",   32'(duty), 0);
        chk("disarm_pe_period", 32'(period), 1_000_000);
        offer(28'd10, 28'd200_000);
        chk("disarm_acc_ready", 32'(tgt_if.tgt_ready), 0);
        arm = 1'b1;
        pulse_pe(1);
        chk("rearm_duty",   32'(duty), 50_000);
        chk("rearm_period", 32'(period), 200_000);
        chk("rearm_state",  32'(state), 1);
        pulse_pe(1);
        chk("low_clamp_state", 32'(state), 2);
        chk("low_clamp_duty",  32'(duty), 50_000);

        // Reset mid-ramp
        offer(28'd80_000, 28'd1_000_000);
        pulse_pe(2);
        chk("pre_rst_duty",  32'(duty), 51_000);
        chk("pre_rst_state", 32'(state), 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_duty",     32'(duty), 0);
        chk("async_period",   32'(period), 1_000_000);
        chk("async_state",    32'(state), 0);
        chk("async_ready",    32'(tgt_if.tgt_ready), 1);
        chk("async_failsafe", 32'(failsafe), 0);
        @(negedge clk) reset_n = 1'b1;
        pulse_pe(1);
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_duty",  32'(duty), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
